bp_update_ctrl: RTL

Branch-resolution and predictor-update controller in the decode stage, sitting between the branch-resolve logic and the DynamicBranchPredictor write port. Each cycle it checks the IF/ID prediction against the resolved outcome and drives the PC redirect and IF/ID flush. Every resolved branch becomes a BHT/BTB write request, held in a small FIFO and drained into the predictor whenever its write port accepts. After reset it walks every BHT/BTB index once to clear it, and keeps saturating branch and mispredict counters.

---
 rtl/bp_update_ctrl_if.sv | 50 +++++
 rtl/bp_update_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bp_update_ctrl_if.sv
// Branch-resolve / predictor-write bundle for bp_update_ctrl.
// master drives resolve inputs and upd_ready; slave is the controller.
interface bp_update_ctrl_if #(
  parameter int IDX_W = 3,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             is_branch;
  logic             actual_taken;
  logic [15:0]      actual_target;
  logic [15:0]      IF_ID_PC_curr;
  logic [1:0]       IF_ID_prediction;
  logic [15:0]      IF_ID_predicted_target;
  logic             upd_ready;
  logic             update_PC;
  logic [15:0]      redirect_target;
  logic             flush_IF_ID;
  logic             stall_fetch;
  logic             upd_valid;
  logic             upd_wen_BHT;
  logic             upd_wen_BTB;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;
  logic [1:0]       upd_prediction;
  logic [15:0]      upd_target;
  logic             init_busy;
  logic             overflow;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output id_valid, is_branch, actual_taken, actual_target,
    output IF_ID_PC_curr, IF_ID_prediction, IF_ID_predicted_target,
    output upd_ready,
    input  update_PC, redirect_target, flush_IF_ID, stall_fetch,
    input  upd_valid, upd_wen_BHT, upd_wen_BTB, upd_index,
    input  upd_taken, upd_prediction, upd_target,
    input  init_busy, overflow, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  id_valid, is_branch, actual_taken, actual_target,
    input  IF_ID_PC_curr, IF_ID_prediction, IF_ID_predicted_target,
    input  upd_ready,
    output update_PC, redirect_target, flush_IF_ID, stall_fetch,
    output upd_valid, upd_wen_BHT, upd_wen_BTB, upd_index,
    output upd_taken, upd_prediction, upd_target,
    output init_busy, overflow, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/bp_update_ctrl.sv
// Branch resolve, redirect/flush and queued BHT/BTB update writer.
// Clears every predictor entry after reset, then drains a small FIFO.
module bp_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 3,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  bp_update_ctrl_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]      C_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]      C_HI   = (PW+1)'(DEPTH - 1);
  localparam logic [PW-1:0]    P_ONE  = PW'(1);
  localparam logic [PW:0]      C_ONE  = (PW+1)'(1);
  localparam logic [IDX_W-1:0] I_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] N_ONE  = CNT_W'(1);

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
    logic [1:0]       pred;
    logic [15:0]      tgt;
    logic             wen_btb;
  } ent_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  ent_t             r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [PW:0]      r_count;
  logic             r_ovf;
  logic [CNT_W-1:0] r_bcnt;
  logic [CNT_W-1:0] r_mcnt;

  logic             w_init;
  logic             w_br;
  logic             w_miss;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [15:0]      w_redir;
  ent_t             w_ent;
  ent_t             w_head;
  logic             w_uv;
  logic             w_ubht;
  logic             w_ubtb;
  logic [IDX_W-1:0] w_uidx;
  logic             w_utk;
  logic [1:0]       w_upred;
  logic [15:0]      w_utgt;

  assign w_head = r_mem[r_rp];

  // Next state, resolve/miss detection, FIFO control and write port mux.
  always_comb begin
    w_next  = r_state;
    w_init  = 1'b0;
    w_br    = 1'b0;
    w_miss  = 1'b0;
    w_full  = (r_count == C_FULL);
    w_pop   = 1'b0;
    w_push  = 1'b0;
    w_drop  = 1'b0;
    w_redir = 16'h0;
    w_ent   = '0;
    w_uv    = 1'b0;
    w_ubht  = 1'b0;
    w_ubtb  = 1'b0;
    w_uidx  = '0;
    w_utk   = 1'b0;
    w_upred = 2'b00;
    w_utgt  = 16'h0;
    unique case (r_state)
      INIT: begin
        w_init = 1'b1;
        w_uv   = 1'b1;
        w_ubht = 1'b1;
        w_ubtb = 1'b1;
        w_uidx = r_idx;
        if (bus.upd_ready && r_idx == '1)
          w_next = RUN;
      end
      RUN: begin
        w_br = bus.id_valid & bus.is_branch;
        w_miss = w_br &
          ((bus.IF_ID_prediction[1] != bus.actual_taken) |
           (bus.actual_taken & bus.IF_ID_prediction[1] &
            (bus.IF_ID_predicted_target != bus.actual_target)));
        if (w_miss)
          w_redir = bus.actual_taken ? bus.actual_target
                                     : bus.IF_ID_PC_curr + 16'd2;
        w_ent.idx     = bus.IF_ID_PC_curr[IDX_W:1];
        w_ent.taken   = bus.actual_taken;
        w_ent.pred    = bus.IF_ID_prediction;
        w_ent.tgt     = bus.actual_target;
        w_ent.wen_btb = bus.actual_taken |
          (bus.IF_ID_predicted_target != bus.actual_target);
        w_pop  = (r_count != '0) & bus.upd_ready;
        w_push = w_br & (~w_full | w_pop);
        w_drop = w_br & w_full & ~w_pop;
        if (r_count != '0) begin
          w_uv    = 1'b1;
          w_ubht  = 1'b1;
          w_ubtb  = w_head.wen_btb;
          w_uidx  = w_head.idx;
          w_utk   = w_head.taken;
          w_upred = w_head.pred;
          w_utgt  = w_head.tgt;
        end
      end
      default: w_next = INIT;
    endcase
  end

  // FSM, clear index, FIFO pointers, sticky overflow and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= INIT;
      r_idx   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_bcnt  <= '0;
      r_mcnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_init && bus.upd_ready)
        r_idx <= r_idx + I_ONE;
      if (w_push)
        r_wp <= r_wp + P_ONE;
      if (w_pop)
        r_rp <= r_rp + P_ONE;
      if (w_push && !w_pop)
        r_count <= r_count + C_ONE;
      else if (w_pop && !w_push)
        r_count <= r_count - C_ONE;
      if (w_drop)
        r_ovf <= 1'b1;
      if (w_push && r_bcnt != '1)
        r_bcnt <= r_bcnt + N_ONE;
      if (w_miss && r_mcnt != '1)
        r_mcnt <= r_mcnt + N_ONE;
    end
  end

  // FIFO storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wp] <= w_ent;
  end

  assign bus.update_PC       = w_miss;
  assign bus.flush_IF_ID     = w_miss;
  assign bus.redirect_target = w_redir;
  assign bus.stall_fetch     = w_init | (r_count >= C_HI);
  assign bus.init_busy       = w_init;
  assign bus.upd_valid       = w_uv;
  assign bus.upd_wen_BHT     = w_ubht;
  assign bus.upd_wen_BTB     = w_ubtb;
  assign bus.upd_index       = w_uidx;
  assign bus.upd_taken       = w_utk;
  assign bus.upd_prediction  = w_upred;
  assign bus.upd_target      = w_utgt;
  assign bus.overflow        = r_ovf;
  assign bus.branch_cnt      = r_bcnt;
  assign bus.mispredict_cnt  = r_mcnt;

endmodule
